// File: rtl/common_pkg.sv
// ============================================================================
// common_pkg : shared sizing constants and scheduler state type
// Revision   : 1.0
// ============================================================================
`default_nettype none

package common_pkg;

    localparam int SYS_ARRAY_SIZE = 4;
    localparam int ROW_BYTES      = 16;
    localparam int ADDR_WIDTH     = 16;
    localparam int TILE_BYTES     = SYS_ARRAY_SIZE * ROW_BYTES;

    // Gap counter holds SYS_ARRAY_SIZE-2 so issue strobes land N cycles apart.
    localparam int GAP_LOAD = (SYS_ARRAY_SIZE > 1) ? (SYS_ARRAY_SIZE - 2) : 0;
    localparam int GAP_W    = (SYS_ARRAY_SIZE > 2) ? $clog2(SYS_ARRAY_SIZE - 1) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        GAP       = 3'd2,
        WAIT_LAST = 3'd3,
        WB_REQ    = 3'd4,
        WB_WAIT   = 3'd5,
        DONE      = 3'd6
    } mm_sched_state_t;

endpackage

`default_nettype wire

// File: rtl/tile_addr_gen.sv
// ============================================================================
// tile_addr_gen : A/B tile address registers with load and incremental step
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tile_addr_gen
    import common_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_i,
    input  logic                  step_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    output logic [ADDR_WIDTH-1:0] addr_a_o,
    output logic [ADDR_WIDTH-1:0] addr_b_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(TILE_BYTES);

    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;

    // Addition wraps naturally modulo 2^ADDR_WIDTH.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            addr_a <= '0;
            addr_b <= '0;
        end else if (load_i) begin
            addr_a <= base_a_i;
            addr_b <= base_b_i;
        end else if (step_i) begin
            addr_a <= addr_a + STEP;
            addr_b <= addr_b + STEP;
        end
    end

    assign addr_a_o = addr_a;
    assign addr_b_o = addr_b;

endmodule

`default_nettype wire

// File: rtl/mm_tile_scheduler.sv
// ============================================================================
// mm_tile_scheduler : issues K-direction tile reads, then a result write-back
// Revision          : 1.0
// ============================================================================
`default_nettype none

module mm_tile_scheduler
    import common_pkg::*;
#(
    parameter int TILE_CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] base_a_i,
    input  logic [ADDR_WIDTH-1:0] base_b_i,
    input  logic [ADDR_WIDTH-1:0] base_c_i,
    input  logic [TILE_CNT_W-1:0] n_tiles_i,
    output logic                  rd_valid_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_a_o,
    output logic [ADDR_WIDTH-1:0] rd_addr_b_o,
    output logic                  rd_last_o,
    input  logic                  sa_last_i,
    output logic                  wb_start_o,
    output logic [ADDR_WIDTH-1:0] wb_addr_o,
    input  logic                  wb_done_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam bit               HAS_GAP   = (SYS_ARRAY_SIZE > 1);
    localparam logic [GAP_W-1:0] GAP_START = GAP_W'(GAP_LOAD);

    mm_sched_state_t       state;
    logic [TILE_CNT_W-1:0] tiles_left;
    logic [GAP_W-1:0]      gap_cnt;
    logic [ADDR_WIDTH-1:0] base_c;
    logic                  addr_load;
    logic                  addr_step;

    assign addr_load = (state == IDLE) && start_i && (n_tiles_i != '0);
    assign addr_step = (state == ISSUE);

    tile_addr_gen u_addr_gen (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (addr_load),
        .step_i   (addr_step),
        .base_a_i (base_a_i),
        .base_b_i (base_b_i),
        .addr_a_o (rd_addr_a_o),
        .addr_b_o (rd_addr_b_o)
    );

    // tiles_left counts tiles not yet issued; it drops at the end of each ISSUE.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            tiles_left <= '0;
            gap_cnt    <= '0;
            base_c     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        if (n_tiles_i != '0) begin
                            tiles_left <= n_tiles_i;
                            base_c     <= base_c_i;
                            state      <= ISSUE;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                ISSUE: begin
                    tiles_left <= tiles_left - 1'b1;
                    gap_cnt    <= GAP_START;
                    if (HAS_GAP) begin
                        state <= GAP;
                    end else if (tiles_left != TILE_CNT_W'(1)) begin
                        state <= ISSUE;
                    end else begin
                        state <= WAIT_LAST;
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state <= (tiles_left != '0) ? ISSUE : WAIT_LAST;
                    end else begin
                        gap_cnt <= gap_cnt - 1'b1;
                    end
                end
                WAIT_LAST: begin
                    if (sa_last_i) begin
                        state <= WB_REQ;
                    end
                end
                WB_REQ: begin
                    state <= WB_WAIT;
                end
                WB_WAIT: begin
                    if (wb_done_i) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Outputs are decodes of registered state only.
    assign rd_valid_o = (state == ISSUE);
    assign rd_last_o  = (state == ISSUE) && (tiles_left == TILE_CNT_W'(1));
    assign wb_start_o = (state == WB_REQ);
    assign wb_addr_o  = base_c;
    assign busy_o     = (state != IDLE);
    assign done_o     = (state == DONE);

endmodule

`default_nettype wire

// File: tb/tb_mm_tile_scheduler.sv
// ============================================================================
// tb_mm_tile_scheduler : directed self-checking bench for mm_tile_scheduler
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_mm_tile_scheduler;
    import common_pkg::*;

    localparam int TCW = 8;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [ADDR_WIDTH-1:0] base_a;
    logic [ADDR_WIDTH-1:0] base_b;
    logic [ADDR_WIDTH-1:0] base_c;
    logic [TCW-1:0]        n_tiles;
    logic                  rd_valid;
    logic [ADDR_WIDTH-1:0] rd_addr_a;
    logic [ADDR_WIDTH-1:0] rd_addr_b;
    logic                  rd_last;
    logic                  sa_last;
    logic                  wb_start;
    logic [ADDR_WIDTH-1:0] wb_addr;
    logic                  wb_done;
    logic                  busy;
    logic                  done;

    int tests;
    int fails;

    mm_tile_scheduler #(.TILE_CNT_W(TCW)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .base_a_i    (base_a),
        .base_b_i    (base_b),
        .base_c_i    (base_c),
        .n_tiles_i   (n_tiles),
        .rd_valid_o  (rd_valid),
        .rd_addr_a_o (rd_addr_a),
        .rd_addr_b_o (rd_addr_b),
        .rd_last_o   (rd_last),
        .sa_last_i   (sa_last),
        .wb_start_o  (wb_start),
        .wb_addr_o   (wb_addr),
        .wb_done_i   (wb_done),
        .busy_o      (busy),
        .done_o      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input logic [7:0] n);
        base_a  = a;
        base_b  = b;
        base_c  = c;
        n_tiles = n;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        rst     = 1'b1;
        start   = 1'b0;
        base_a  = '0;
        base_b  = '0;
        base_c  = '0;
        n_tiles = '0;
        sa_last = 1'b0;
        wb_done = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_wb_addr", 32'(wb_addr), 32'h0);
        rst = 1'b0;
        tick();

        // 3-tile job: issues at cycles 1, 5, 9; stray sa_last during GAP ignored
        launch(16'h0100, 16'h0800, 16'h1234, 8'd3);
        for (int c = 1; c <= 13; c++) begin
            sa_last = (c == 2);
            chk($sformatf("t1_valid_c%0d", c), 32'(rd_valid), 32'((c == 1) || (c == 5) || (c == 9)));
            chk($sformatf("t1_busy_c%0d", c), 32'(busy), 32'd1);
            if (c == 1 || c == 5 || c == 9) begin
                chk($sformatf("t1_a_c%0d", c), 32'(rd_addr_a), 32'h0100 + 32'((c - 1) / 4) * 32'h40);
                chk($sformatf("t1_b_c%0d", c), 32'(rd_addr_b), 32'h0800 + 32'((c - 1) / 4) * 32'h40);
                chk($sformatf("t1_last_c%0d", c), 32'(rd_last), 32'(c == 9));
            end
            chk($sformatf("t1_wbs_c%0d", c), 32'(wb_start), 32'd0);
            tick();
        end
        sa_last = 1'b1;
        tick();
        sa_last = 1'b0;
        chk("t1_wb_start", 32'(wb_start), 32'd1);
        chk("t1_wb_addr", 32'(wb_addr), 32'h1234);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        chk("t1_wb_start_off", 32'(wb_start), 32'd0);
        chk("t1_wbwait_nodone", 32'(done), 32'd0);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        chk("t1_done", 32'(done), 32'd1);
        tick();
        chk("t1_idle_done", 32'(done), 32'd0);
        chk("t1_idle_busy", 32'(busy), 32'd0);

        // 1-tile job; wb_done during WB_REQ ignored
        launch(16'h0200, 16'h0300, 16'hABCD, 8'd1);
        chk("t2_valid", 32'(rd_valid), 32'd1);
        chk("t2_last", 32'(rd_last), 32'd1);
        chk("t2_a", 32'(rd_addr_a), 32'h0200);
        chk("t2_b", 32'(rd_addr_b), 32'h0300);
        for (int c = 2; c <= 5; c++) begin
            tick();
            chk($sformatf("t2_quiet_c%0d", c), 32'(rd_valid), 32'd0);
        end
        sa_last = 1'b1;
        tick();
        sa_last = 1'b0;
        chk("t2_wb_start", 32'(wb_start), 32'd1);
        chk("t2_wb_addr", 32'(wb_addr), 32'hABCD);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        chk("t2_wbreq_done_ignored", 32'(done), 32'd0);
        chk("t2_wbwait_busy", 32'(busy), 32'd1);
        chk("t2_wb_addr_held", 32'(wb_addr), 32'hABCD);
        tick();
        chk("t2_still_waiting", 32'(done), 32'd0);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        tick();
        chk("t2_idle", 32'(busy), 32'd0);

        // Zero-tile job
        launch(16'h0A00, 16'h0B00, 16'h0C00, 8'd0);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_no_valid", 32'(rd_valid), 32'd0);
        chk("t3_no_wb", 32'(wb_start), 32'd0);
        tick();
        chk("t3_idle_done", 32'(done), 32'd0);
        chk("t3_idle_busy", 32'(busy), 32'd0);

        // start pulses during GAP and WB_WAIT are ignored
        launch(16'h1000, 16'h2000, 16'h3000, 8'd2);
        chk("t4_a0", 32'(rd_addr_a), 32'h1000);
        tick();
        base_a  = 16'h5000;
        base_b  = 16'h6000;
        base_c  = 16'h7000;
        n_tiles = 8'd7;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        tick();
        tick();
        chk("t4_valid2", 32'(rd_valid), 32'd1);
        chk("t4_a1", 32'(rd_addr_a), 32'h1040);
        chk("t4_b1", 32'(rd_addr_b), 32'h2040);
        chk("t4_last", 32'(rd_last), 32'd1);
        for (int c = 6; c <= 9; c++) begin
            tick();
            chk($sformatf("t4_novalid_c%0d", c), 32'(rd_valid), 32'd0);
        end
        sa_last = 1'b1;
        tick();
        sa_last = 1'b0;
        chk("t4_wb_addr", 32'(wb_addr), 32'h3000);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_wbwait_busy", 32'(busy), 32'd1);
        chk("t4_wbwait_nodone", 32'(done), 32'd0);
        chk("t4_wb_addr_held", 32'(wb_addr), 32'h3000);
        wb_done = 1'b1;
        tick();
        wb_done = 1'b0;
        chk("t4_done", 32'(done), 32'd1);
        tick();
        chk("t4_idle", 32'(busy), 32'd0);

        // Reset mid-GAP aborts the job
        launch(16'h0400, 16'h0500, 16'h0900, 8'd3);
        tick();
        rst = 1'b1;
        #1;
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_valid", 32'(rd_valid), 32'd0);
        chk("t5_last", 32'(rd_last), 32'd0);
        chk("t5_wbs", 32'(wb_start), 32'd0);
        chk("t5_done", 32'(done), 32'd0);
        chk("t5_a", 32'(rd_addr_a), 32'h0);
        chk("t5_b", 32'(rd_addr_b), 32'h0);
        chk("t5_wb_addr", 32'(wb_addr), 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("t5_nodone_c%0d", c), 32'(done | busy | rd_valid), 32'd0);
        end
        launch(16'h0600, 16'h0700, 16'h0800, 8'd1);
        chk("t5_new_valid", 32'(rd_valid), 32'd1);
        chk("t5_new_a", 32'(rd_addr_a), 32'h0600);
        chk("t5_new_b", 32'(rd_addr_b), 32'h0700);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Address wrap at 2^16
        launch(16'hFFC0, 16'h0010, 16'h4444, 8'd2);
        chk("t6_a0", 32'(rd_addr_a), 32'hFFC0);
        tick();
        tick();
        tick();
        tick();
        chk("t6_valid2", 32'(rd_valid), 32'd1);
        chk("t6_a1_wrap", 32'(rd_addr_a), 32'h0000);
        chk("t6_b1", 32'(rd_addr_b), 32'h0050);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mm_tile_scheduler.md
MM_TILE_SCHEDULER -- requirements
Module: mm_tile_scheduler

Interface
REQ-001 Parameter TILE_CNT_W, default 8: width of the tile-count input and the internal tile counter.
REQ-002 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_i  input  1  asynchronous, active-high reset.
REQ-004 start_i  input  1  job request; sampled only in IDLE.
REQ-005 base_a_i, base_b_i  input  ADDR_WIDTH each  byte addresses of the first A and B tiles.
REQ-006 base_c_i  input  ADDR_WIDTH  byte address for the result write-back.
REQ-007 n_tiles_i  input  TILE_CNT_W  number of K-direction tiles to accumulate.
REQ-008 rd_valid_o  output  1  tile-issue strobe to the read data handler.
REQ-009 rd_addr_a_o, rd_addr_b_o  output  ADDR_WIDTH each  tile start addresses, valid with rd_valid_o.
REQ-010 rd_last_o  output  1  marks the final tile; drives the handler's we_i.
REQ-011 sa_last_i  input  1  last-data pulse from the read data handler.
REQ-012 wb_start_o  output  1  one-cycle write-back request.
REQ-013 wb_addr_o  output  ADDR_WIDTH  write-back address; held stable while in WB_WAIT.
REQ-014 wb_done_i  input  1  write-back completion pulse.
REQ-015 busy_o  output  1  high in every state except IDLE.
REQ-016 done_o  output  1  one-cycle job-complete pulse.

Function
REQ-017 The FSM SHALL have exactly the states IDLE, ISSUE, GAP, WAIT_LAST, WB_REQ, WB_WAIT and DONE.
REQ-018 IDLE SHALL transition as follows:
- start_i=1, n_tiles_i>0: latch all base_* inputs and n_tiles_i, go to ISSUE.
- start_i=1, n_tiles_i=0: go to DONE; no reads and no write-back are issued.
REQ-019 ISSUE SHALL behave as follows for exactly one cycle:
- assert rd_valid_o with the current tile addresses;
- assert rd_last_o iff this is the final tile;
- load the gap counter with SYS_ARRAY_SIZE-2.
REQ-020 ISSUE SHALL go to GAP when SYS_ARRAY_SIZE>1, and otherwise go directly to the next-tile decision of REQ-021.
REQ-021 GAP SHALL decrement the gap counter each cycle; when it reaches 0:
- if tiles remain, go to ISSUE;
- otherwise go to WAIT_LAST.
REQ-022 Consecutive rd_valid_o pulses SHALL therefore be exactly SYS_ARRAY_SIZE cycles apart, which matches the handler's N-cycle occupancy.
REQ-023 Tile address arithmetic:
- tile t address = base + t*TILE_BYTES, where TILE_BYTES = SYS_ARRAY_SIZE*ROW_BYTES;
- computed by an incremental adder, not a multiplier;
- wraps modulo 2^ADDR_WIDTH with no error flag.
REQ-024 WAIT_LAST SHALL hold until sa_last_i=1, then go to WB_REQ. An sa_last_i pulse seen in any other state SHALL be ignored.
REQ-025 WB_REQ SHALL assert wb_start_o for one cycle with wb_addr_o = latched base_c, then go to WB_WAIT.
REQ-026 WB_WAIT SHALL hold until wb_done_i=1, then go to DONE. A wb_done_i arriving while in WB_REQ SHALL be ignored.
REQ-027 DONE SHALL assert done_o for one cycle, then go to IDLE. A new start_i is accepted at the earliest in the following cycle.
REQ-028 start_i SHALL be ignored in every state except IDLE; inputs changing mid-job SHALL have no effect.
REQ-029 All outputs SHALL be registered or pure state decodes, with no combinational path from any input to any output.

Reset
REQ-030 On rst_i=1, regardless of state, the FSM SHALL go to IDLE and all counters and address registers SHALL clear to 0.
REQ-031 During reset every output SHALL be 0, including busy_o, done_o, rd_valid_o, rd_last_o and wb_start_o.
REQ-032 Reset asserted mid-job SHALL abort the job; no done_o pulse SHALL follow the abort.

Structure
REQ-033 The following SHALL come from common_pkg:
- SYS_ARRAY_SIZE, ROW_BYTES and ADDR_WIDTH;
- a new TILE_BYTES constant;
- the state enum type mm_sched_state_t.
REQ-034 The block SHALL contain one sub-module, tile_addr_gen, which holds the A/B address registers with load and step controls.

Verification
REQ-035 The bench SHALL cover the following directed scenarios (SYS_ARRAY_SIZE=4, ROW_BYTES=16):
- start, n_tiles=3, base_a=0x100, base_b=0x800 -> rd_valid at cycles 1, 5, 9; A addresses 0x100/0x140/0x180, B addresses 0x800/0x840/0x880; rd_last only on the third issue.
- n_tiles=1 -> single issue with rd_last=1; sa_last pulse -> wb_start one cycle later with wb_addr=base_c; wb_done -> done_o next cycle.
- n_tiles=0 -> done_o one cycle after start; no rd_valid and no wb_start.
- start_i pulsed during GAP and WB_WAIT -> ignored; the job completes unchanged.
- rst_i asserted mid-GAP of a 3-tile job -> all outputs 0 immediately; a new job afterwards starts from its own base.
- base_a=0xFFC0, ADDR_WIDTH=16, n_tiles=2 -> second A address 0x0000 (wrap).
